// File: rtl/spi_sd_command_sequencer.sv
// SD-card SPI-mode command sequencer: detects received command frames, runs the card
// initialisation state machine and streams R1/R3/R7 response bytes over valid/ready.
module spi_sd_command_sequencer #(
   parameter logic [31:0] OCR          = 32'hC0FF8000,
   parameter int          ACMD41_POLLS = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  io_Command,
   input  logic [31:0] io_CommandArgument,
   input  logic        io_ReadSuccess,
   output logic        io_Response_valid,
   output logic [7:0]  io_Response_bits,
   input  logic        io_Response_ready,
   output logic        io_Busy,
   input  logic [1:0]  io_Avalon_address,
   input  logic        io_Avalon_read,
   output logic [63:0] io_Avalon_readdata,
   output logic        io_Avalon_waitrequest
);

   localparam logic [1:0]  ST_INACTIVE = 2'd0;
   localparam logic [1:0]  ST_IDLE     = 2'd1;
   localparam logic [1:0]  ST_READY    = 2'd2;
   localparam logic [0:0]  FSM_WAIT    = 1'b0;
   localparam logic [0:0]  FSM_SEND    = 1'b1;
   localparam logic [15:0] POLL_RELOAD = 16'(ACMD41_POLLS);

   logic        r_hist;
   logic [1:0]  r_card_state;
   logic        r_app;
   logic [15:0] r_poll_cnt;
   logic [0:0]  r_fsm;
   logic [7:0]  r_buf [0:4];
   logic [2:0]  r_len;
   logic [2:0]  r_idx;
   logic        r_valid;
   logic [7:0]  r_bits;
   logic        r_busy;
   logic [15:0] r_cmd_cnt;
   logic [15:0] r_drop_cnt;
   logic [5:0]  r_last_cmd;
   logic [31:0] r_last_arg;

   logic        w_new_frame;
   logic        w_idle;
   logic [15:0] w_poll_dec;
   logic        w_accept;
   logic [1:0]  w_next_state;
   logic        w_next_app;
   logic [15:0] w_next_poll;
   logic [7:0]  w_buf [0:4];
   logic [2:0]  w_len;

   assign w_new_frame = io_ReadSuccess & ~r_hist;
   assign w_idle      = (r_card_state != ST_READY);
   assign w_poll_dec  = r_poll_cnt - 16'd1;

   // Command decode: next card state, flags and the response bytes for the current frame
   always_comb begin
      w_accept     = 1'b0;
      w_next_state = r_card_state;
      w_next_app   = 1'b0;
      w_next_poll  = r_poll_cnt;
      w_len        = 3'd1;
      for (int i = 0; i < 5; i++) begin
         w_buf[i] = 8'h00;
      end
      // Until CMD0 arrives the card stays silent for every other command
      if ((r_card_state == ST_INACTIVE) && (io_Command != 6'd0)) begin
         w_accept = 1'b0;
      end else begin
         w_accept = 1'b1;
         case (io_Command)
            6'd0: begin
               w_next_state = ST_IDLE;
               w_next_poll  = POLL_RELOAD;
               w_buf[0]     = 8'h01;
            end
            6'd8: begin
               w_buf[0] = {7'b0, w_idle};
               w_buf[3] = {4'h0, io_CommandArgument[11:8]};
               w_buf[4] = io_CommandArgument[7:0];
               w_len    = 3'd5;
            end
            6'd55: begin
               w_next_app = 1'b1;
               w_buf[0]   = {7'b0, w_idle};
            end
            6'd41: begin
               if (r_app) begin
                  if (r_card_state == ST_IDLE) begin
                     w_next_poll = w_poll_dec;
                     if (w_poll_dec == 16'd0) begin
                        w_next_state = ST_READY;
                     end else begin
                        w_next_state = ST_IDLE;
                     end
                  end else begin
                     w_next_poll = r_poll_cnt;
                  end
                  w_buf[0] = {7'b0, (w_next_state != ST_READY)};
               end else begin
                  w_buf[0] = {5'b0, 1'b1, 1'b0, w_idle};
               end
            end
            6'd58: begin
               w_buf[0] = {7'b0, w_idle};
               w_buf[1] = {(r_card_state == ST_READY), OCR[30:24]};
               w_buf[2] = OCR[23:16];
               w_buf[3] = OCR[15:8];
               w_buf[4] = OCR[7:0];
               w_len    = 3'd5;
            end
            default: begin
               w_buf[0] = {5'b0, 1'b1, 1'b0, w_idle};
            end
         endcase
      end
   end

   // Frame capture, card state update and response byte streaming
   always_ff @(posedge clock) begin
      if (reset) begin
         r_hist       <= 1'b1;
         r_card_state <= ST_INACTIVE;
         r_app        <= 1'b0;
         r_poll_cnt   <= POLL_RELOAD;
         r_fsm        <= FSM_WAIT;
         for (int i = 0; i < 5; i++) begin
            r_buf[i] <= 8'h00;
         end
         r_len        <= 3'd0;
         r_idx        <= 3'd0;
         r_valid      <= 1'b0;
         r_bits       <= 8'h00;
         r_busy       <= 1'b0;
         r_cmd_cnt    <= 16'd0;
         r_drop_cnt   <= 16'd0;
         r_last_cmd   <= 6'd0;
         r_last_arg   <= 32'd0;
      end else begin
         r_hist <= io_ReadSuccess;
         case (r_fsm)
            FSM_WAIT: begin
               if (w_new_frame) begin
                  r_last_cmd <= io_Command;
                  r_last_arg <= io_CommandArgument;
                  if (w_accept) begin
                     r_card_state <= w_next_state;
                     r_app        <= w_next_app;
                     r_poll_cnt   <= w_next_poll;
                     for (int i = 0; i < 5; i++) begin
                        r_buf[i] <= w_buf[i];
                     end
                     r_len     <= w_len;
                     r_idx     <= 3'd0;
                     r_valid   <= 1'b1;
                     r_bits    <= w_buf[0];
                     r_busy    <= 1'b1;
                     r_fsm     <= FSM_SEND;
                     r_cmd_cnt <= r_cmd_cnt + 16'd1;
                  end
               end
            end
            FSM_SEND: begin
               if (w_new_frame) begin
                  r_drop_cnt <= r_drop_cnt + 16'd1;
               end
               if (r_valid && io_Response_ready) begin
                  if (r_idx == (r_len - 3'd1)) begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_bits  <= 8'h00;
                     r_fsm   <= FSM_WAIT;
                  end else begin
                     r_idx  <= r_idx + 3'd1;
                     r_bits <= r_buf[r_idx + 3'd1];
                  end
               end
            end
            default: begin
               r_fsm <= FSM_WAIT;
            end
         endcase
      end
   end

   assign io_Response_valid     = r_valid;
   assign io_Response_bits      = r_bits;
   assign io_Busy               = r_busy;
   assign io_Avalon_waitrequest = 1'b0;

   // Debug CSR read window
   always_comb begin
      io_Avalon_readdata = 64'd0;
      if (io_Avalon_read) begin
         case (io_Avalon_address)
            2'd0:    io_Avalon_readdata = {56'd0, 6'd0, r_card_state};
            2'd1:    io_Avalon_readdata = {32'd0, r_drop_cnt, r_cmd_cnt};
            2'd2:    io_Avalon_readdata = {26'd0, r_last_cmd, r_last_arg};
            2'd3:    io_Avalon_readdata = {32'd0, OCR};
            default: io_Avalon_readdata = 64'd0;
         endcase
      end else begin
         io_Avalon_readdata = 64'd0;
      end
   end

endmodule

// File: tb/tb_spi_sd_command_sequencer.sv
// Bench for spi_sd_command_sequencer: a transaction-level card model predicts every
// response byte and CSR value; directed sequences add literal expectations.
module tb_spi_sd_command_sequencer;

   localparam logic [31:0] OCR   = 32'hC0FF8000;
   localparam int          POLLS = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic [5:0]  io_Command;
   logic [31:0] io_CommandArgument;
   logic        io_ReadSuccess;
   logic        io_Response_valid;
   logic [7:0]  io_Response_bits;
   logic        io_Response_ready;
   logic        io_Busy;
   logic [1:0]  io_Avalon_address;
   logic        io_Avalon_read;
   logic [63:0] io_Avalon_readdata;
   logic        io_Avalon_waitrequest;

   int n_cmp = 0;
   int n_err = 0;

   spi_sd_command_sequencer #(.OCR(OCR), .ACMD41_POLLS(POLLS)) dut (
      .clock(clock), .reset(reset),
      .io_Command(io_Command), .io_CommandArgument(io_CommandArgument),
      .io_ReadSuccess(io_ReadSuccess),
      .io_Response_valid(io_Response_valid), .io_Response_bits(io_Response_bits),
      .io_Response_ready(io_Response_ready), .io_Busy(io_Busy),
      .io_Avalon_address(io_Avalon_address), .io_Avalon_read(io_Avalon_read),
      .io_Avalon_readdata(io_Avalon_readdata), .io_Avalon_waitrequest(io_Avalon_waitrequest)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- card model (transaction level) ----------------
   logic        m_hist = 1'b1;
   int          m_state = 0;        // 0 inactive, 1 idle, 2 ready
   logic        m_app = 1'b0;
   int          m_polls = POLLS;
   logic [15:0] m_cmd_cnt = 16'd0;
   logic [15:0] m_drop_cnt = 16'd0;
   logic [5:0]  m_last_cmd = 6'd0;
   logic [31:0] m_last_arg = 32'd0;
   logic [7:0]  m_q[$];
   logic        m_sending = 1'b0;

   task automatic m_respond(input logic [5:0] cmd, input logic [31:0] arg);
      logic [7:0] idle;
      if (m_state == 0 && cmd != 6'd0) return;
      idle = (m_state != 2) ? 8'h01 : 8'h00;
      m_cmd_cnt++;
      if (cmd == 6'd0) begin
         m_state = 1; m_polls = POLLS; m_app = 1'b0;
         m_q.push_back(8'h01);
      end else if (cmd == 6'd8) begin
         m_app = 1'b0;
         m_q.push_back(idle); m_q.push_back(8'h00); m_q.push_back(8'h00);
         m_q.push_back({4'h0, arg[11:8]}); m_q.push_back(arg[7:0]);
      end else if (cmd == 6'd55) begin
         m_app = 1'b1;
         m_q.push_back(idle);
      end else if (cmd == 6'd41 && m_app) begin
         m_app = 1'b0;
         if (m_state == 1) begin
            m_polls--;
            if (m_polls == 0) m_state = 2;
         end
         m_q.push_back((m_state != 2) ? 8'h01 : 8'h00);
      end else if (cmd == 6'd58) begin
         m_app = 1'b0;
         m_q.push_back(idle);
         m_q.push_back({(m_state == 2), OCR[30:24]});
         m_q.push_back(OCR[23:16]); m_q.push_back(OCR[15:8]); m_q.push_back(OCR[7:0]);
      end else begin
         m_app = 1'b0;
         m_q.push_back(idle | 8'h04);
      end
      m_sending = 1'b1;
   endtask

   initial begin
      forever begin
         @(posedge clock);
         if (reset) begin
            m_hist = 1'b1; m_state = 0; m_app = 1'b0; m_polls = POLLS;
            m_cmd_cnt = 16'd0; m_drop_cnt = 16'd0; m_last_cmd = 6'd0; m_last_arg = 32'd0;
            m_q.delete(); m_sending = 1'b0;
         end else begin
            logic frame;
            frame  = io_ReadSuccess & ~m_hist;
            m_hist = io_ReadSuccess;
            if (m_sending) begin
               if (frame) m_drop_cnt++;
               if (io_Response_ready) void'(m_q.pop_front());
               if (m_q.size() == 0) m_sending = 1'b0;
            end else if (frame) begin
               m_last_cmd = io_Command;
               m_last_arg = io_CommandArgument;
               m_respond(io_Command, io_CommandArgument);
            end
         end
      end
   end

   // Per-cycle compare of DUT outputs against the model
   initial begin
      @(posedge clock);
      forever begin
         @(negedge clock);
         check("valid", io_Response_valid, m_sending);
         check("busy", io_Busy, m_sending);
         check("waitrequest", io_Avalon_waitrequest, 0);
         if (m_sending && m_q.size() > 0) check("bits", io_Response_bits, m_q[0]);
         if (io_Avalon_read) begin
            logic [63:0] e;
            case (io_Avalon_address)
               2'd0:    e = 64'(m_state);
               2'd1:    e = {32'd0, m_drop_cnt, m_cmd_cnt};
               2'd2:    e = {26'd0, m_last_cmd, m_last_arg};
               default: e = {32'd0, OCR};
            endcase
            check("csr_model", io_Avalon_readdata, e);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic csr(input string name, input logic [1:0] addr, input logic [63:0] exp);
      io_Avalon_address = addr; io_Avalon_read = 1'b1;
      @(negedge clock);
      check(name, io_Avalon_readdata, exp);
      @(posedge clock); #1;
      io_Avalon_read = 1'b0;
   endtask

   task automatic recv(input string name, input int n, input logic [39:0] exp);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         @(negedge clock);
         while (!io_Response_valid && t < 20) begin
            @(negedge clock);
            t++;
         end
         check({name, "_valid"}, io_Response_valid, 1);
         check(name, io_Response_bits, exp[39-8*i -: 8]);
         @(posedge clock); #1;
      end
      @(negedge clock);
      check({name, "_done"}, io_Busy, 0);
      @(posedge clock); #1;
   endtask

   task automatic run_cmd(input string name, input logic [5:0] cmd, input logic [31:0] arg,
                          input int n, input logic [39:0] exp);
      io_Command = cmd; io_CommandArgument = arg; io_ReadSuccess = 1'b1;
      @(posedge clock); #1;
      io_ReadSuccess = 1'b0;
      if (n == 0) begin
         repeat (3) begin
            @(negedge clock);
            check({name, "_silent"}, io_Response_valid, 0);
         end
         @(posedge clock); #1;
      end else begin
         recv(name, n, exp);
      end
   endtask

   initial begin
      reset = 1'b1; io_ReadSuccess = 1'b1; io_Command = 6'd0; io_CommandArgument = 32'd0;
      io_Response_ready = 1'b1; io_Avalon_address = 2'd0; io_Avalon_read = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_valid", io_Response_valid, 0);
      check("rst_bits", io_Response_bits, 8'h00);
      check("rst_busy", io_Busy, 0);
      @(negedge clock);
      check("level_through_reset", io_Response_valid, 0);
      @(posedge clock); #1;
      io_ReadSuccess = 1'b0;
      csr("rst_state", 2'd0, 64'd0);
      csr("rst_cnt", 2'd1, 64'd0);
      csr("ocr", 2'd3, 64'h0000_0000_C0FF_8000);

      run_cmd("cmd8_inactive", 6'd8, 32'h1AA, 0, 40'h0);
      csr("cnt_inactive", 2'd1, 64'd0);
      run_cmd("cmd0", 6'd0, 32'h0, 1, 40'h01_00_00_00_00);
      csr("state_idle", 2'd0, 64'd1);
      run_cmd("cmd8_r7", 6'd8, 32'h0000_01AA, 5, 40'h01_00_00_01_AA);
      csr("last_cmd", 2'd2, 64'h0000_0008_0000_01AA);
      run_cmd("cmd58_idle", 6'd58, 32'h0, 5, 40'h01_40_FF_80_00);
      run_cmd("cmd41_noapp", 6'd41, 32'h0, 1, 40'h05_00_00_00_00);
      run_cmd("cmd55_a", 6'd55, 32'h0, 1, 40'h01_00_00_00_00);
      run_cmd("acmd41_a", 6'd41, 32'h4000_0000, 1, 40'h01_00_00_00_00);
      run_cmd("cmd55_b", 6'd55, 32'h0, 1, 40'h01_00_00_00_00);
      run_cmd("acmd41_b", 6'd41, 32'h4000_0000, 1, 40'h00_00_00_00_00);
      csr("state_ready", 2'd0, 64'd2);
      run_cmd("cmd58_ready", 6'd58, 32'h0, 5, 40'h00_C0_FF_80_00);
      run_cmd("cmd17", 6'd17, 32'h0, 1, 40'h04_00_00_00_00);
      csr("cnt10", 2'd1, 64'h0000_0000_0000_000A);

      // Backpressure with a frame arriving mid-response
      io_Response_ready = 1'b0;
      io_Command = 6'd8; io_CommandArgument = 32'h0000_03C5; io_ReadSuccess = 1'b1;
      @(posedge clock); #1 io_ReadSuccess = 1'b0;
      @(negedge clock); check("hold0", io_Response_bits, 8'h00);
      @(posedge clock); #1 io_ReadSuccess = 1'b1; io_Command = 6'd0;
      @(negedge clock); check("hold1", io_Response_bits, 8'h00);
      @(posedge clock); #1 io_ReadSuccess = 1'b0;
      @(negedge clock); check("hold_valid", io_Response_valid, 1);
      @(posedge clock); #1;
      csr("drop1", 2'd1, 64'h0000_0000_0001_000B);
      io_Response_ready = 1'b1;
      recv("r7_after_hold", 5, 40'h00_00_00_03_C5);

      // Reset in the middle of a response
      io_Command = 6'd58; io_ReadSuccess = 1'b1;
      @(posedge clock); #1 io_ReadSuccess = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      check("midrst_valid", io_Response_valid, 0);
      check("midrst_busy", io_Busy, 0);
      @(posedge clock); #1;
      csr("midrst_state", 2'd0, 64'd0);
      csr("midrst_cnt", 2'd1, 64'd0);
      csr("midrst_last", 2'd2, 64'd0);
      repeat (2) @(posedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
